keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clk cycles each row is driven; legal range >= 2.
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical scan frames needed to confirm a press or a release; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 col  input  3  keypad column sense, active-low (pulled up), asynchronous to clk.
REQ-006 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-007 tenkey  output  10  one-hot digit strobe; bit n set means digit n; all-zero when idle.
REQ-008 close  output  1  one-cycle strobe on a confirmed '#' press.
REQ-009 key_valid  output  1  one-cycle strobe, high in the same cycle as any tenkey or close strobe.

Function
REQ-010 Keypad map (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = '*',0,'#'.
REQ-011 Row sequencing: row cycles 4'b1110 -> 1101 -> 1011 -> 0111 -> 1110; each value is held exactly SCAN_DIV cycles; a dwell counter runs 0..SCAN_DIV-1 and wraps.
REQ-012 col passes through a 2-flop synchronizer before use.
REQ-013 Sampling: the synchronized col is sampled for the current row in the cycle where the dwell counter equals SCAN_DIV-1.
REQ-014 Frame: the four row samples (r0..r3) form one frame of 4*SCAN_DIV cycles; the frame result is evaluated when the r3 sample is taken.
REQ-015 Frame result is exactly one of: NONE (no key low), KEY(code) (exactly one key low, code 0-11), MULTI (two or more keys low).
REQ-016 State machine: IDLE, PRESS_CONFIRM, HELD, RELEASE_CONFIRM; a confirm counter counts 0..DEBOUNCE.
REQ-017 IDLE: on KEY(c), latch c, set count=1, go to PRESS_CONFIRM; on NONE or MULTI, stay in IDLE.
REQ-018 PRESS_CONFIRM: on KEY(c) with c equal to the latched code, increment count; on KEY(c') with a different code, latch c' and set count=1; on NONE or MULTI, go to IDLE with count=0.
REQ-019 When count reaches DEBOUNCE: emit the strobe in the next cycle and go to HELD; this applies with DEBOUNCE=1 on the first KEY frame from IDLE.
REQ-020 Strobe contents: digits 0-9 set tenkey bit = digit and key_valid=1 for exactly one cycle; '#' sets close=1 and key_valid=1 with tenkey=0; '*' emits no strobe but still enters HELD.
REQ-021 HELD: on NONE, set count=1 and go to RELEASE_CONFIRM; on KEY of any code or MULTI, stay in HELD, so a second key pressed while holding is ignored.
REQ-022 RELEASE_CONFIRM: on NONE, increment count; on KEY or MULTI, return to HELD; when count reaches DEBOUNCE, go to IDLE with no strobe.
REQ-023 At most one strobe per confirmed press; tenkey, close and key_valid are zero in every cycle that carries no strobe.
REQ-024 Strobes are registered outputs; no combinational path from col to any output.

Reset
REQ-025 While reset=0: row=4'b1110, tenkey=10'b0, close=0, key_valid=0, state=IDLE, dwell, confirm count and latched code all cleared, synchronizer flops set to 3'b111.
REQ-026 Reset asserted mid-frame or mid-confirm aborts that activity with no strobe; after release, scanning restarts at r0 with dwell=0.
REQ-027 A key still held across reset is treated as a new press and strobes again after DEBOUNCE frames.

Verification (SCAN_DIV=4, DEBOUNCE=3, frame = 16 cycles)
REQ-028 Hold '5' (r1,c1) for 6 frames, then release -> exactly one cycle with tenkey=10'b0000100000 and key_valid=1, at the end of the 3rd full frame; row sequence correct throughout.
REQ-029 Hold '#' for 4 frames -> one cycle with close=1, key_valid=1, tenkey=0; hold '*' -> no strobe.
REQ-030 Bouncing '3' (present 2 frames, absent 1, repeated 5 times) -> no strobe; state never leaves IDLE/PRESS_CONFIRM.
REQ-031 Press '1' and '2' together for 5 frames -> no strobe; press '7', release 2 frames, press '7' again -> only one strobe total.
REQ-032 Hold '9' until the strobe, then press '4' additionally -> no second strobe; release all for 3 frames, then press '4' -> tenkey=10'b0000010000 once.
REQ-033 Assert reset during HELD on '0' while the key stays pressed -> outputs zero and row=4'b1110 during reset; after release, tenkey=10'b0000000001 strobes once after 3 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad one row at a time and debounces
// whole scan frames. Each confirmed key press produces a single registered
// strobe on tenkey/close with key_valid.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [9:0] tenkey,
    output logic       close,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CONFIRM,
        S_HELD,
        S_RELEASE_CONFIRM
    } state_t;

    logic [2:0]    r_colMeta;
    logic [2:0]    r_colSync;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_rowIdx;
    logic [8:0]    r_frame;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [3:0]    r_code;
    logic [9:0]    r_tenkey;
    logic          r_close;
    logic          r_keyValid;

    logic          w_sampleTick;
    logic          w_frameDone;
    logic [11:0]   w_keys;
    logic [3:0]    w_keyCount;
    logic [3:0]    w_keyCode;
    logic          w_isNone;
    logic          w_isKey;
    state_t        w_stateNext;
    logic [CW-1:0] w_countNext;
    logic [3:0]    w_codeNext;
    logic          w_confirm;
    logic [9:0]    w_tenkeyNext;
    logic          w_closeNext;
    logic          w_validNext;

    // The last row sample of a frame is taken live from the synchronizer,
    // so the frame can be judged in the same cycle it is completed.
    assign w_sampleTick = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frameDone  = w_sampleTick && (r_rowIdx == 2'd3);
    assign w_keys       = {~r_colSync, r_frame};
    assign w_isNone     = (w_keyCount == 4'd0);
    assign w_isKey      = (w_keyCount == 4'd1);

    assign row       = ~(4'b0001 << r_rowIdx);
    assign tenkey    = r_tenkey;
    assign close     = r_close;
    assign key_valid = r_keyValid;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_colMeta <= 3'b111;
            r_colSync <= 3'b111;
        end else begin
            r_colMeta <= col;
            r_colSync <= r_colMeta;
        end
    end

    // Row dwell counter and row index; rows advance after SCAN_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell  <= '0;
            r_rowIdx <= 2'd0;
        end else if (w_sampleTick) begin
            r_dwell  <= '0;
            r_rowIdx <= r_rowIdx + 2'd1;
        end else begin
            r_dwell  <= r_dwell + DW'(1);
        end
    end

    // Capture rows 0..2 of the frame as active-high key bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame <= '0;
        end else if (w_sampleTick) begin
            case (r_rowIdx)
                2'd0:    r_frame[2:0] <= ~r_colSync;
                2'd1:    r_frame[5:3] <= ~r_colSync;
                2'd2:    r_frame[8:6] <= ~r_colSync;
                default: r_frame      <= r_frame;
            endcase
        end
    end

    // Classify the frame: how many keys are down and which one was last seen.
    always_comb begin
        w_keyCount = 4'd0;
        w_keyCode  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w_keys[i]) begin
                w_keyCount = w_keyCount + 4'd1;
                w_keyCode  = 4'(i);
            end
        end
    end

    // Debounce state machine: next state, counter, latched code and strobes.
    always_comb begin
        w_stateNext  = r_state;
        w_countNext  = r_count;
        w_codeNext   = r_code;
        w_confirm    = 1'b0;
        w_tenkeyNext = '0;
        w_closeNext  = 1'b0;
        w_validNext  = 1'b0;
        if (w_frameDone) begin
            case (r_state)
                S_IDLE: begin
                    if (w_isKey) begin
                        w_codeNext  = w_keyCode;
                        w_countNext = CW'(1);
                        w_stateNext = S_PRESS_CONFIRM;
                    end
                end
                S_PRESS_CONFIRM: begin
                    if (w_isKey && (w_keyCode == r_code)) begin
                        w_countNext = r_count + CW'(1);
                    end else if (w_isKey) begin
                        w_codeNext  = w_keyCode;
                        w_countNext = CW'(1);
                    end else begin
                        w_countNext = '0;
                        w_stateNext = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_isNone) begin
                        w_countNext = CW'(1);
                        w_stateNext = S_RELEASE_CONFIRM;
                    end
                end
                default: begin
                    if (w_isNone) begin
                        w_countNext = r_count + CW'(1);
                    end else begin
                        w_countNext = '0;
                        w_stateNext = S_HELD;
                    end
                end
            endcase
            if ((w_stateNext == S_PRESS_CONFIRM) && (w_countNext == CW'(DEBOUNCE))) begin
                w_stateNext = S_HELD;
                w_countNext = '0;
                w_confirm   = 1'b1;
            end
            if ((w_stateNext == S_RELEASE_CONFIRM) && (w_countNext == CW'(DEBOUNCE))) begin
                w_stateNext = S_IDLE;
                w_countNext = '0;
            end
        end
        if (w_confirm) begin
            if (w_codeNext < 4'd9) begin
                w_tenkeyNext = 10'b1 << (w_codeNext + 4'd1);
                w_validNext  = 1'b1;
            end else if (w_codeNext == 4'd10) begin
                w_tenkeyNext = 10'b0000000001;
                w_validNext  = 1'b1;
            end else if (w_codeNext == 4'd11) begin
                w_closeNext  = 1'b1;
                w_validNext  = 1'b1;
            end
        end
    end

    // State, counter and latched code registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_code  <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_code  <= w_codeNext;
        end
    end

    // Registered strobe outputs, zero in every cycle without a confirmation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tenkey   <= '0;
            r_close    <= 1'b0;
            r_keyValid <= 1'b0;
        end else begin
            r_tenkey   <= w_tenkeyNext;
            r_close    <= w_closeNext;
            r_keyValid <= w_validNext;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x3 keypad matrix into keypad_scanner
// and checks every strobe against a queue of expected key events.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [9:0]  tenkey;
    logic        close;
    logic        key_valid;
    logic [11:0] pressed = '0;

    int nChecks   = 0;
    int nFails    = 0;
    int nStrobes  = 0;
    int strobeCyc = -1;
    int cyc       = 0;

    logic [10:0] sbQ[$];
    logic [10:0] monExp;
    logic [3:0]  monRow;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk),
        .reset(reset),
        .col(col),
        .row(row),
        .tenkey(tenkey),
        .close(close),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & ~pressed[r*3 +: 3];
        end
    end

    // Cycles since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Row sequence check and scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        monRow = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
        nChecks++;
        if (row !== monRow) begin
            nFails++;
            $display("[TB] FAIL row_seq cyc=%0d got=%b want=%b", cyc, row, monRow);
        end
        if (key_valid === 1'b1) begin
            nStrobes++;
            strobeCyc = cyc;
            nChecks++;
            if (sbQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected_strobe tenkey=%b close=%b want=no strobe", tenkey, close);
            end else begin
                monExp = sbQ.pop_front();
                if ({tenkey, close} !== monExp) begin
                    nFails++;
                    $display("[TB] FAIL strobe_value got tenkey=%b close=%b want tenkey=%b close=%b",
                             tenkey, close, monExp[10:1], monExp[0]);
                end
            end
        end else begin
            nChecks++;
            if ((tenkey !== 10'b0) || (close !== 1'b0) || (key_valid !== 1'b0)) begin
                nFails++;
                $display("[TB] FAIL idle_outputs tenkey=%b close=%b key_valid=%b want all zero",
                         tenkey, close, key_valid);
            end
        end
    end

    // Advance n clocks, ending just after a rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset and release it with the given keys already held.
    task automatic doReset(input logic [11:0] keys);
        reset = 1'b0;
        cycles(3);
        pressed = keys;
        strobeCyc = -1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pressed = '0;
        cycles(3);
        nChecks++;
        if (row !== 4'b1110) begin nFails++; $display("[TB] FAIL reset_row got=%b want=1110", row); end
        nChecks++;
        if (tenkey !== 10'b0) begin nFails++; $display("[TB] FAIL reset_tenkey got=%b want=0", tenkey); end
        nChecks++;
        if (close !== 1'b0) begin nFails++; $display("[TB] FAIL reset_close got=%b want=0", close); end
        nChecks++;
        if (key_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_key_valid got=%b want=0", key_valid); end
        reset = 1'b1;
        cycles(2 * FRAME);
    endtask

    task automatic test_digit5();
        int s0;
        s0 = nStrobes;
        sbQ.push_back({10'b0000100000, 1'b0});
        doReset(12'b1 << 4);
        cycles(6 * FRAME);
        nChecks++;
        if (strobeCyc != 3 * FRAME) begin nFails++; $display("[TB] FAIL digit5_time got=%0d want=%0d", strobeCyc, 3 * FRAME); end
        pressed = '0;
        cycles(4 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 1) begin nFails++; $display("[TB] FAIL digit5_count got=%0d want=1", nStrobes - s0); end
        nChecks++;
        if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL digit5_pending got=%0d want=0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_hash_star();
        int s0;
        s0 = nStrobes;
        doReset('0);
        sbQ.push_back({10'b0, 1'b1});
        pressed = 12'b1 << 11;
        cycles(4 * FRAME);
        pressed = '0;
        cycles(4 * FRAME);
        pressed = 12'b1 << 9;
        cycles(4 * FRAME);
        pressed = '0;
        cycles(4 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 1) begin nFails++; $display("[TB] FAIL hash_star_count got=%0d want=1", nStrobes - s0); end
        nChecks++;
        if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL hash_star_pending got=%0d want=0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_bounce();
        int s0;
        s0 = nStrobes;
        doReset('0);
        for (int k = 0; k < 5; k++) begin
            pressed = 12'b1 << 2;
            cycles(2 * FRAME);
            pressed = '0;
            cycles(FRAME);
        end
        cycles(2 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 0) begin nFails++; $display("[TB] FAIL bounce_count got=%0d want=0", nStrobes - s0); end
    endtask

    task automatic test_multi();
        int s0;
        s0 = nStrobes;
        doReset('0);
        pressed = 12'b000000000011;
        cycles(5 * FRAME);
        pressed = '0;
        cycles(2 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 0) begin nFails++; $display("[TB] FAIL multi_count got=%0d want=0", nStrobes - s0); end
        sbQ.push_back({10'b0010000000, 1'b0});
        pressed = 12'b1 << 6;
        cycles(4 * FRAME);
        pressed = '0;
        cycles(2 * FRAME);
        pressed = 12'b1 << 6;
        cycles(4 * FRAME);
        pressed = '0;
        cycles(4 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 1) begin nFails++; $display("[TB] FAIL seven_count got=%0d want=1", nStrobes - s0); end
        nChecks++;
        if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL seven_pending got=%0d want=0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = nStrobes;
        doReset('0);
        sbQ.push_back({10'b1000000000, 1'b0});
        pressed = 12'b1 << 8;
        cycles(4 * FRAME);
        pressed = pressed | (12'b1 << 3);
        cycles(4 * FRAME);
        pressed = '0;
        cycles(3 * FRAME);
        sbQ.push_back({10'b0000010000, 1'b0});
        pressed = 12'b1 << 3;
        cycles(4 * FRAME);
        nChecks++;
        if (strobeCyc != 14 * FRAME) begin nFails++; $display("[TB] FAIL four_time got=%0d want=%0d", strobeCyc, 14 * FRAME); end
        pressed = '0;
        cycles(4 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 2) begin nFails++; $display("[TB] FAIL b2b_count got=%0d want=2", nStrobes - s0); end
        nChecks++;
        if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL b2b_pending got=%0d want=0", sbQ.size()); sbQ.delete(); end
    endtask

    task automatic test_reset_held();
        int s0;
        s0 = nStrobes;
        sbQ.push_back({10'b0000000001, 1'b0});
        doReset(12'b1 << 10);
        cycles(4 * FRAME);
        nChecks++;
        if (strobeCyc != 3 * FRAME) begin nFails++; $display("[TB] FAIL zero_time got=%0d want=%0d", strobeCyc, 3 * FRAME); end
        cycles(7);
        reset = 1'b0;
        cycles(2);
        nChecks++;
        if (row !== 4'b1110) begin nFails++; $display("[TB] FAIL midreset_row got=%b want=1110", row); end
        nChecks++;
        if ({tenkey, close, key_valid} !== 12'b0) begin
            nFails++;
            $display("[TB] FAIL midreset_outputs tenkey=%b close=%b key_valid=%b want zero", tenkey, close, key_valid);
        end
        sbQ.push_back({10'b0000000001, 1'b0});
        strobeCyc = -1;
        cycles(2);
        reset = 1'b1;
        cycles(4 * FRAME);
        nChecks++;
        if (strobeCyc != 3 * FRAME) begin nFails++; $display("[TB] FAIL zero_repress_time got=%0d want=%0d", strobeCyc, 3 * FRAME); end
        pressed = '0;
        cycles(4 * FRAME);
        nChecks++;
        if (nStrobes - s0 != 2) begin nFails++; $display("[TB] FAIL zero_count got=%0d want=2", nStrobes - s0); end
        nChecks++;
        if (sbQ.size() != 0) begin nFails++; $display("[TB] FAIL zero_pending got=%0d want=0", sbQ.size()); sbQ.delete(); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        $display("[TB] keypad_scanner bench start");
        test_reset();
        test_digit5();
        test_hash_star();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
